// File: rtl/cpt_bin_mod.sv
// rtl/cpt_bin_mod.sv - parametrised synchronous modulo counter with load, direction and wrap/saturate ends
module cpt_bin_mod #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULO   = 256,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             activate,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    // Top of range held in WIDTH bits, so a full-range counter compares against all-ones.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'd1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             at_top, at_bot;

    assign at_top = (out_q == MAX_VAL);
    assign at_bot = (out_q == '0);

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (load) begin
            out_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (activate) begin
            if (up_down) begin
                if (!at_top) begin
                    out_d = out_q + WIDTH'(1);
                end else if (!SATURATE) begin
                    out_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    out_d = out_q - WIDTH'(1);
                end else if (!SATURATE) begin
                    out_d  = MAX_VAL;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign tc   = up_down ? at_top : at_bot;

endmodule

// File: tb/tb_cpt_bin_mod.sv
// tb/tb_cpt_bin_mod.sv - directed checks of cpt_bin_mod across four parameter builds
module tb_cpt_bin_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // a: 8-bit full range, b: modulo 10 wrap, c: 4-bit saturate, d: 16-bit full range
    logic       a_reset, a_act, a_up, a_load, a_tc, a_wrap;
    logic [7:0] a_lv, a_out;
    logic       b_reset, b_act, b_up, b_load, b_tc, b_wrap;
    logic [3:0] b_lv, b_out;
    logic       c_reset, c_act, c_up, c_load, c_tc, c_wrap;
    logic [3:0] c_lv, c_out;
    logic        d_reset, d_act, d_up, d_load, d_tc, d_wrap;
    logic [15:0] d_lv, d_out;

    cpt_bin_mod #(.WIDTH(8), .MODULO(256), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(a_reset), .activate(a_act), .up_down(a_up), .load(a_load),
        .load_val(a_lv), .out(a_out), .tc(a_tc), .wrap(a_wrap));
    cpt_bin_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_b (
        .clk(clk), .reset(b_reset), .activate(b_act), .up_down(b_up), .load(b_load),
        .load_val(b_lv), .out(b_out), .tc(b_tc), .wrap(b_wrap));
    cpt_bin_mod #(.WIDTH(4), .MODULO(16), .SATURATE(1'b1)) u_c (
        .clk(clk), .reset(c_reset), .activate(c_act), .up_down(c_up), .load(c_load),
        .load_val(c_lv), .out(c_out), .tc(c_tc), .wrap(c_wrap));
    cpt_bin_mod #(.WIDTH(16), .MODULO(65536), .SATURATE(1'b0)) u_d (
        .clk(clk), .reset(d_reset), .activate(d_act), .up_down(d_up), .load(d_load),
        .load_val(d_lv), .out(d_out), .tc(d_tc), .wrap(d_wrap));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_reset = 0; b_reset = 0; c_reset = 0; d_reset = 0;
        a_act = 1; b_act = 1; c_act = 1; d_act = 1;
        a_up = 1; b_up = 1; c_up = 1; d_up = 1;
        a_load = 0; b_load = 0; c_load = 0; d_load = 0;
        a_lv = 0; b_lv = 0; c_lv = 0; d_lv = 0;
        step(); step();
        checks++;
        if ({a_out, b_out, c_out, d_out} !== 32'h0) begin
            failures++;
            $display("FAIL reset_out: got a=%0h b=%0h c=%0h d=%0h expected all 0", a_out, b_out, c_out, d_out);
        end
        checks++;
        if ({a_wrap, b_wrap, c_wrap, d_wrap} !== 4'b0) begin
            failures++;
            $display("FAIL reset_wrap: got %b expected 0000", {a_wrap, b_wrap, c_wrap, d_wrap});
        end
        checks++;
        if ({a_tc, b_tc, c_tc, d_tc} !== 4'b0) begin
            failures++;
            $display("FAIL reset_tc_up: got %b expected 0000", {a_tc, b_tc, c_tc, d_tc});
        end
        a_act = 0; b_act = 0; c_act = 0; d_act = 0;
        a_reset = 1; b_reset = 1; c_reset = 1; d_reset = 1;
        step();
        checks++;
        if ({a_out, b_out, c_out, d_out} !== 32'h0) begin
            failures++;
            $display("FAIL reset_release_idle: got a=%0h b=%0h c=%0h d=%0h expected all 0", a_out, b_out, c_out, d_out);
        end
    endtask

    task automatic test_reset_mid_count();
        a_act = 1; a_up = 1;
        for (int i = 0; i < 8'h37; i++) step();
        checks++;
        if (a_out !== 8'h37) begin
            failures++;
            $display("FAIL mid_count_reach: got %0h expected 37", a_out);
        end
        a_reset = 0; a_load = 1; a_lv = 8'h55;
        step();
        checks++;
        if (a_out !== 8'h00 || a_wrap !== 1'b0) begin
            failures++;
            $display("FAIL mid_count_reset: got out=%0h wrap=%b expected out=00 wrap=0", a_out, a_wrap);
        end
        a_reset = 1; a_load = 0; a_act = 0;
    endtask

    task automatic test_up_wrap();
        b_act = 1; b_up = 1;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (b_out !== 4'(i % 10) || b_tc !== ((i % 10) == 9) || b_wrap !== (i == 10)) begin
                failures++;
                $display("FAIL up_wrap step %0d: got out=%0d tc=%b wrap=%b expected out=%0d tc=%b wrap=%b",
                         i, b_out, b_tc, b_wrap, i % 10, (i % 10) == 9, i == 10);
            end
        end
        b_act = 0;
    endtask

    task automatic test_down_dir_change();
        int exp_out [3] = '{1, 0, 9};
        b_load = 1; b_lv = 4'd2;
        step();
        checks++;
        if (b_out !== 4'd2 || b_wrap !== 1'b0) begin
            failures++;
            $display("FAIL down_load: got out=%0d wrap=%b expected out=2 wrap=0", b_out, b_wrap);
        end
        b_load = 0; b_act = 1; b_up = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b_out !== 4'(exp_out[i]) || b_wrap !== (i == 2) || b_tc !== (exp_out[i] == 0)) begin
                failures++;
                $display("FAIL down_step %0d: got out=%0d wrap=%b tc=%b expected out=%0d wrap=%b tc=%b",
                         i, b_out, b_wrap, b_tc, exp_out[i], i == 2, exp_out[i] == 0);
            end
        end
        b_up = 1;
        #1;
        checks++;
        if (b_tc !== 1'b1) begin
            failures++;
            $display("FAIL dir_change_tc: got %b expected 1", b_tc);
        end
        step();
        checks++;
        if (b_out !== 4'd0 || b_wrap !== 1'b1) begin
            failures++;
            $display("FAIL dir_change_wrap: got out=%0d wrap=%b expected out=0 wrap=1", b_out, b_wrap);
        end
        b_act = 0;
        step();
        checks++;
        if (b_out !== 4'd0 || b_wrap !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_wrap: got out=%0d wrap=%b expected out=0 wrap=0", b_out, b_wrap);
        end
    endtask

    task automatic test_saturate();
        c_act = 1; c_up = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (c_out !== 4'((i > 15) ? 15 : i) || c_wrap !== 1'b0) begin
                failures++;
                $display("FAIL sat_up step %0d: got out=%0d wrap=%b expected out=%0d wrap=0",
                         i, c_out, c_wrap, (i > 15) ? 15 : i);
            end
        end
        checks++;
        if (c_tc !== 1'b1) begin
            failures++;
            $display("FAIL sat_up_tc: got %b expected 1", c_tc);
        end
        c_up = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (c_out !== 4'((i > 15) ? 0 : 15 - i) || c_wrap !== 1'b0) begin
                failures++;
                $display("FAIL sat_down step %0d: got out=%0d wrap=%b expected out=%0d wrap=0",
                         i, c_out, c_wrap, (i > 15) ? 0 : 15 - i);
            end
        end
        checks++;
        if (c_tc !== 1'b1) begin
            failures++;
            $display("FAIL sat_down_tc: got %b expected 1", c_tc);
        end
        c_act = 0;
    endtask

    task automatic test_load_clamp();
        b_load = 1; b_act = 1; b_up = 1; b_lv = 4'd7;
        step();
        checks++;
        if (b_out !== 4'd7) begin
            failures++;
            $display("FAIL load_priority: got %0d expected 7", b_out);
        end
        b_lv = 4'd12;
        step();
        checks++;
        if (b_out !== 4'd9 || b_tc !== 1'b1) begin
            failures++;
            $display("FAIL load_clamp: got out=%0d tc=%b expected out=9 tc=1", b_out, b_tc);
        end
        b_lv = 4'd10;
        step();
        checks++;
        if (b_out !== 4'd9 || b_wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_clamp_edge: got out=%0d wrap=%b expected out=9 wrap=0", b_out, b_wrap);
        end
        b_load = 0; b_act = 0;
        step(); step();
        checks++;
        if (b_out !== 4'd9) begin
            failures++;
            $display("FAIL hold_after_load: got %0d expected 9", b_out);
        end
    endtask

    task automatic test_full_range();
        d_load = 1; d_lv = 16'hFFFF; d_act = 0; d_up = 1;
        step();
        checks++;
        if (d_out !== 16'hFFFF || d_tc !== 1'b1) begin
            failures++;
            $display("FAIL wide_load: got out=%0h tc=%b expected out=ffff tc=1", d_out, d_tc);
        end
        d_load = 0; d_act = 1;
        step();
        checks++;
        if (d_out !== 16'h0000 || d_wrap !== 1'b1) begin
            failures++;
            $display("FAIL wide_wrap: got out=%0h wrap=%b expected out=0 wrap=1", d_out, d_wrap);
        end
        d_act = 0;
        step();
        checks++;
        if (d_out !== 16'h0000 || d_wrap !== 1'b0) begin
            failures++;
            $display("FAIL wide_hold: got out=%0h wrap=%b expected out=0 wrap=0", d_out, d_wrap);
        end
        d_act = 1; d_up = 0;
        step();
        checks++;
        if (d_out !== 16'hFFFF || d_wrap !== 1'b1) begin
            failures++;
            $display("FAIL wide_down_wrap: got out=%0h wrap=%b expected out=ffff wrap=1", d_out, d_wrap);
        end
        d_act = 0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_up_wrap();
        test_down_dir_change();
        test_saturate();
        test_load_clamp();
        test_full_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
